// File: rtl/sar_search_ctrl_pkg.sv
//==============================================================================
// Module : sar_search_ctrl_pkg
// Brief  : Shared FSM state encoding and comparator code constants for the
//          successive-approximation search controller.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

package sar_search_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DECIDE = 2'd2,
      DONE   = 2'd3
   } sar_state_t;

   // Comparator code ordering is {aeqb, agtb, altb}
   localparam logic [2:0] CMP_EQ = 3'b100;
   localparam logic [2:0] CMP_GT = 3'b010;
   localparam logic [2:0] CMP_LT = 3'b001;

endpackage

`default_nettype wire

// File: rtl/sar_search_ctrl.sv
//==============================================================================
// Module : sar_search_ctrl
// Brief  : Successive-approximation search controller; drives a trial operand
//          into a magnitude comparator and resolves the unknown operand.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module sar_search_ctrl
   import sar_search_ctrl_pkg::*;
#(
   parameter int WIDTH         = 4,
   parameter int SETTLE_CYCLES = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_aeqb,
   input  logic             cmp_agtb,
   input  logic             cmp_altb,
   output logic [WIDTH-1:0] trial,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [WIDTH-1:0] result
);

   localparam int c_cnt_w = (SETTLE_CYCLES > 0) ? $clog2(SETTLE_CYCLES + 1) : 1;
   localparam int c_idx_w = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(SETTLE_CYCLES);
   localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
   localparam logic [c_idx_w-1:0] c_idx_init = c_idx_w'(WIDTH - 1);
   localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

   sar_state_t         r_state, w_state_nxt, w_go_state;
   logic [WIDTH-1:0]   r_trial, w_trial_nxt, w_trial_upd;
   logic [WIDTH-1:0]   r_result, w_result_nxt;
   logic [c_idx_w-1:0] r_idx, w_idx_nxt;
   logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
   logic               r_busy, w_busy_nxt;
   logic               r_done, w_done_nxt;
   logic               r_err, w_err_nxt;
   logic [2:0]         w_code;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= IDLE;
         r_trial  <= '0;
         r_result <= '0;
         r_idx    <= '0;
         r_cnt    <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_trial  <= w_trial_nxt;
         r_result <= w_result_nxt;
         r_idx    <= w_idx_nxt;
         r_cnt    <= w_cnt_nxt;
         r_busy   <= w_busy_nxt;
         r_done   <= w_done_nxt;
         r_err    <= w_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_trial_nxt  = r_trial;
      w_trial_upd  = r_trial;
      w_result_nxt = r_result;
      w_idx_nxt    = r_idx;
      w_cnt_nxt    = r_cnt;
      w_busy_nxt   = r_busy;
      w_done_nxt   = 1'b0;
      w_err_nxt    = 1'b0;
      w_code       = {cmp_aeqb, cmp_agtb, cmp_altb};
      w_go_state   = (SETTLE_CYCLES > 0) ? SETTLE : DECIDE;

      case (r_state)
         IDLE, DONE: begin
            if (start) begin
               w_trial_nxt            = '0;
               w_trial_nxt[WIDTH-1]   = 1'b1;
               w_idx_nxt              = c_idx_init;
               w_cnt_nxt              = c_cnt_load;
               w_busy_nxt             = 1'b1;
               w_state_nxt            = w_go_state;
            end
         end
         SETTLE: begin
            w_cnt_nxt = r_cnt - c_cnt_one;
            if (w_cnt_nxt == '0) begin
               w_state_nxt = DECIDE;
            end
         end
         DECIDE: begin
            case (w_code)
               CMP_EQ: begin
                  w_result_nxt = r_trial;
                  w_done_nxt   = 1'b1;
                  w_busy_nxt   = 1'b0;
                  w_state_nxt  = DONE;
               end
               CMP_GT, CMP_LT: begin
                  // Data below the trial means the trial bit under test is too big
                  if (w_code == CMP_LT) begin
                     w_trial_upd[r_idx] = 1'b0;
                  end
                  if (r_idx == '0) begin
                     w_trial_nxt  = w_trial_upd;
                     w_result_nxt = w_trial_upd;
                     w_done_nxt   = 1'b1;
                     w_busy_nxt   = 1'b0;
                     w_state_nxt  = DONE;
                  end else begin
                     w_trial_upd[r_idx - c_idx_one] = 1'b1;
                     w_trial_nxt = w_trial_upd;
                     w_idx_nxt   = r_idx - c_idx_one;
                     w_cnt_nxt   = c_cnt_load;
                     w_state_nxt = w_go_state;
                  end
               end
               default: begin
                  w_err_nxt   = 1'b1;
                  w_busy_nxt  = 1'b0;
                  w_state_nxt = IDLE;
               end
            endcase
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign trial  = r_trial;
   assign result = r_result;
   assign busy   = r_busy;
   assign done   = r_done;
   assign err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_sar_search_ctrl.sv
//==============================================================================
// Module : tb_sar_search_ctrl
// Brief  : Scoreboard bench for sar_search_ctrl with a behavioural comparator.
// Rev    : 1.0  initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_sar_search_ctrl;

   typedef struct {
      bit         is_err;
      logic [3:0] res;
      int         lat;
      int         scyc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start0, start2;
   logic [3:0] a0, a2;
   logic       f0_en;
   logic [2:0] f0_code;

   logic       aeqb0, agtb0, altb0, aeqb2, agtb2, altb2;
   logic [3:0] trial0, result0, trial2, result2;
   logic       busy0, done0, err0, busy2, done2, err2;

   int   cyc  = 0;
   int   nvec = 0;
   int   nmis = 0;
   exp_t q0[$];
   exp_t q2[$];
   exp_t e0, e2;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Behavioural magnitude comparator; dut0 can have its code overridden
   assign {aeqb0, agtb0, altb0} = f0_en ? f0_code : {a0 == trial0, a0 > trial0, a0 < trial0};
   assign {aeqb2, agtb2, altb2} = {a2 == trial2, a2 > trial2, a2 < trial2};

   sar_search_ctrl #(.WIDTH(4), .SETTLE_CYCLES(0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0),
      .cmp_aeqb(aeqb0), .cmp_agtb(agtb0), .cmp_altb(altb0),
      .trial(trial0), .busy(busy0), .done(done0), .err(err0), .result(result0)
   );

   sar_search_ctrl #(.WIDTH(4), .SETTLE_CYCLES(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .start(start2),
      .cmp_aeqb(aeqb2), .cmp_agtb(agtb2), .cmp_altb(altb2),
      .trial(trial2), .busy(busy2), .done(done2), .err(err2), .result(result2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic cmp_exp(input string tag, input exp_t e, input logic d, input logic er,
                          input logic b, input logic [3:0] r, input logic [3:0] t,
                          input int bound);
      int lat;
      lat = cyc - e.scyc;
      check({tag, " done&err"}, {31'd0, d & er}, 0);
      check({tag, " kind"}, {31'd0, er}, {31'd0, e.is_err});
      check({tag, " result"}, {28'd0, r}, {28'd0, e.res});
      check({tag, " trial"}, {28'd0, t}, e.is_err ? 32'd8 : {28'd0, e.res});
      check({tag, " busy"}, {31'd0, b}, 0);
      if (e.lat >= 0) check({tag, " latency"}, lat, e.lat);
      else            check({tag, " latency<=bound"}, {31'd0, lat <= bound}, 1);
   endtask

   always @(negedge clk) begin
      if (rst_n && (done0 || err0)) begin
         if (q0.size() == 0) check("dut0 unexpected output", 0, 1);
         else begin
            e0 = q0.pop_front();
            cmp_exp("dut0", e0, done0, err0, busy0, result0, trial0, 4);
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && (done2 || err2)) begin
         if (q2.size() == 0) check("dut2 unexpected output", 0, 1);
         else begin
            e2 = q2.pop_front();
            cmp_exp("dut2", e2, done2, err2, busy2, result2, trial2, 12);
         end
      end
   end

   task automatic run(input bit sel, input logic [3:0] a, input int lat, input bit eerr,
                      input logic [3:0] eres, input bit dbl);
      @(negedge clk);
      if (!sel) begin
         a0 = a; start0 = 1'b1;
         q0.push_back('{is_err: eerr, res: eres, lat: lat, scyc: cyc + 1});
      end else begin
         a2 = a; start2 = 1'b1;
         q2.push_back('{is_err: eerr, res: eres, lat: lat, scyc: cyc + 1});
      end
      @(negedge clk);
      start0 = 1'b0; start2 = 1'b0;
      check("busy after start", {31'd0, sel ? busy2 : busy0}, 1);
      if (dbl) begin
         @(negedge clk);
         if (!sel) start0 = 1'b1; else start2 = 1'b1;
         @(negedge clk);
         start0 = 1'b0; start2 = 1'b0;
      end
      for (int k = 0; k < 60; k++) begin
         @(posedge clk);
         if ((sel ? q2.size() : q0.size()) == 0) break;
      end
      check("drain before timeout", sel ? q2.size() : q0.size(), 0);
      if (!sel) q0.delete(); else q2.delete();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start0 = 1'b0; start2 = 1'b0;
      a0 = '0; a2 = '0; f0_en = 1'b0; f0_code = 3'b000;
      repeat (3) @(negedge clk);
      check("rst trial0", {28'd0, trial0}, 0);
      check("rst result0", {28'd0, result0}, 0);
      check("rst busy/done/err0", {29'd0, busy0, done0, err0}, 0);
      check("rst trial2/result2", {24'd0, trial2, result2}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Hand-worked searches on the zero-settle instance
      run(0, 4'd4,  2, 0, 4'd4,  0);
      run(0, 4'd10, 3, 0, 4'd10, 0);
      run(0, 4'd0,  4, 0, 4'd0,  0);
      run(0, 4'd15, 4, 0, 4'd15, 0);
      for (int v = 0; v < 16; v++) run(0, 4'(v), -1, 0, 4'(v), 0);

      // Illegal comparator code aborts at the first decision, old result kept
      f0_en = 1'b1; f0_code = 3'b011;
      run(0, 4'd3, 1, 1, 4'd15, 0);
      check("state after err accepts start", {31'd0, busy0}, 0);
      f0_en = 1'b0;
      run(0, 4'd6, 3, 0, 4'd6, 0);

      // Second start during a search is ignored; latency is from the first start
      run(0, 4'd10, 3, 0, 4'd10, 1);

      // Settle instance: three cycles per trial
      run(1, 4'd5, 12, 0, 4'd5, 0);
      run(1, 4'd0, 12, 0, 4'd0, 0);
      run(1, 4'd8,  3, 0, 4'd8, 0);

      // Asynchronous reset in the middle of a search
      @(negedge clk);
      a0 = 4'd0; start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      @(negedge clk);
      check("mid busy before reset", {31'd0, busy0}, 1);
      #2 rst_n = 1'b0;
      #1;
      check("mid-rst trial0", {28'd0, trial0}, 0);
      check("mid-rst result0", {28'd0, result0}, 0);
      check("mid-rst busy/done/err0", {29'd0, busy0, done0, err0}, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run(0, 4'd10, 3, 0, 4'd10, 0);

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule

`default_nettype wire
